vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//  Downstream of the VGA timing generator. Consumes pixel_x/pixel_y/future_x and hs/vs/de.
//  Fetches the 256x256 4-bitplane Vector-06C frame from video RAM and serialises it.
//  Maps each 4-bit pixel index through a 16-entry palette.
//  Emits registered 8-bit colour (BBGGGRRR) with sync and DE re-aligned to it.
//  Display: 2x horizontal, 2x vertical; 512x480 window inside the 640x480 active area.
// PARAMETERS
//  H_START   64  first pixel_x of picture window (window is H_START..H_START+511)
//  ROW_SKIP  8   source rows skipped at top of frame before scroll is applied
//  VRAM_LAT  1   cycles from vram_rd to vram_data valid; legal 1..4
// PORTS
//  clk         in   1   pixel clock, shared with timing generator
//  reset_n     in   1   synchronous active-low reset
//  pixel_x     in   12  current active x, 12'hfff outside active area
//  pixel_y     in   12  current active y, 12'hfff outside active area
//  future_x    in   12  pixel_x + 6, 12'hfff before lead-in
//  in_hs       in   1   horizontal sync from timing generator
//  in_vs       in   1   vertical sync from timing generator
//  in_de       in   1   data enable from timing generator
//  scroll_y    in   8   vertical scroll register, sampled when pixel_y==0 && pixel_x==0
//  border_idx  in   4   palette index used outside the picture window
//  pal_we      in   1   palette write strobe
//  pal_addr    in   4   palette entry written
//  pal_data    in   8   palette write data
//  vram_rd     out  1   one-cycle read request
//  vram_addr   out  13  {column[4:0], row[7:0]}
//  vram_data   in   32  {plane3,plane2,plane1,plane0} bytes, valid VRAM_LAT cycles after vram_rd
//  rgb         out  8   output colour BBGGGRRR
//  out_hs      out  1   in_hs delayed 1 cycle
//  out_vs      out  1   in_vs delayed 1 cycle
//  out_de      out  1   in_de delayed 1 cycle
// BEHAVIOUR
//  Reset, sync on reset_n==0:
//   - rgb, vram_rd, vram_addr, out_de = 0; out_hs, out_vs = 1.
//   - Palette, shift regs, hold regs and latched scroll = 0; FSM -> IDLE.
//   - Mid-line reset discards any in-flight read; its returning data is ignored.
//  Window:
//   - in_win = pixel_x in [H_START, H_START+511] and pixel_y != 12'hfff.
//   - fx = future_x - H_START; fetch window is fx in [0,511].
//  Row:
//   - row = scroll_lat - ROW_SKIP - pixel_y[8:1], 8-bit wrap.
//   - Frame is stored bottom-up, so row decreases down the screen.
//  Fetch FSM:
//   - IDLE -> REQ when fx[3:0]==0 in fetch window; REQ drives vram_rd=1 for one cycle,
//     vram_addr={fx[8:4],row}.
//   - REQ -> WAIT; WAIT counts VRAM_LAT-1 cycles, then CAPTURE.
//   - CAPTURE latches vram_data into hold[31:0]; -> IDLE.
//   - 32 requests per active line, none during blanking (future_x==12'hfff).
//  Serialiser:
//   - When in_win and (pixel_x-H_START)[3:0]==0, the 4 plane shift regs load from hold.
//   - Otherwise they shift left on every odd (pixel_x-H_START), i.e. each source pixel lasts 2 clocks.
//   - idx = {sh3[7],sh2[7],sh1[7],sh0[7]}.
//   - Load and shift never coincide; load wins by definition.
//  Output, 1-cycle latency:
//   - rgb(t+1) = !in_de(t) ? 0 : in_win(t) ? pal[idx] : pal[border_idx].
//   - out_hs/out_vs/out_de are registered copies, so rgb stays aligned with out_de.
//  Palette:
//   - Write on clk when pal_we.
//   - Same-cycle write and read of one entry: read returns the OLD value; new value from next cycle.
//  Scroll:
//   - scroll_y changes mid-frame are ignored until the next latch point.
// TESTING
//  - Reset: hold reset_n=0 4 clks -> rgb=0, out_hs=out_vs=1, vram_rd=0, no requests.
//  - Single line: palette[5]=8'hE0, VRAM={00,FF,00,FF} all addrs -> window rgb=E0 for 512 clks; border elsewhere.
//  - Fetch cadence: run one line -> exactly 32 vram_rd pulses, addr col 0..31.
//    First pulse at pixel_x=H_START-6; data captured before pixel_x=H_START for VRAM_LAT=1..4.
//  - Row mapping: scroll_y=8'hFF, ROW_SKIP=8 -> pixel_y 0,1 fetch row F7; pixel_y 2 fetches row F6.
//    Scroll change mid-frame takes effect only next frame.
//  - Pattern: plane0 byte 8'hA5 in col 0, others 0 -> idx sequence 1,0,1,0,0,1,0,1, each 2 clks.
//  - Palette hazard: write pal[border_idx]=8'h1C while displaying border -> old colour same cycle, 1C next.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches 4-bitplane VRAM words, serialises them at 2x scale and maps through a palette
module vga_pixel_fetch #(
   parameter int H_START  = 64,
   parameter int ROW_SKIP = 8,
   parameter int VRAM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] pixel_x,
   input  logic [11:0] pixel_y,
   input  logic [11:0] future_x,
   input  logic        in_hs,
   input  logic        in_vs,
   input  logic        in_de,
   input  logic [7:0]  scroll_y,
   input  logic [3:0]  border_idx,
   input  logic        pal_we,
   input  logic [3:0]  pal_addr,
   input  logic [7:0]  pal_data,
   output logic        vram_rd,
   output logic [12:0] vram_addr,
   input  logic [31:0] vram_data,
   output logic [7:0]  rgb,
   output logic        out_hs,
   output logic        out_vs,
   output logic        out_de
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} state_t;
   state_t      state, state_nx;
   logic [1:0]  cnt;
   logic [11:0] fx, px;
   logic [7:0]  row, scroll_lat;
   logic [31:0] hold;
   logic [7:0]  sh [4];
   logic [7:0]  pal [16];
   logic        in_win, fetch, load;
   logic [3:0]  idx;

   assign fx     = future_x - 12'(H_START);
   assign px     = pixel_x - 12'(H_START);
   assign in_win = px < 12'd512 && pixel_y != 12'hfff;
   assign fetch  = fx < 12'd512 && fx[3:0] == 4'd0;
   assign row    = scroll_lat - 8'(ROW_SKIP) - pixel_y[8:1];
   assign load   = in_win && px[3:0] == 4'd0;
   // the load cycle shows the freshly fetched word before it reaches the shifters
   assign idx    = load ? {hold[31], hold[23], hold[15], hold[7]}
                        : {sh[3][7], sh[2][7], sh[1][7], sh[0][7]};

   always_comb begin
      state_nx = state == IDLE ? (fetch ? REQ : IDLE)
               : state == REQ  ? (VRAM_LAT == 1 ? CAPTURE : WAIT)
               : state == WAIT ? (cnt == 2'(VRAM_LAT - 2) ? CAPTURE : WAIT)
               : IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         vram_rd    <= 1'b0;
         vram_addr  <= 13'd0;
         hold       <= 32'd0;
         scroll_lat <= 8'd0;
      end else begin
         state   <= state_nx;
         cnt     <= state == WAIT ? cnt + 2'd1 : 2'd0;
         vram_rd <= state == IDLE && fetch;
         if (state == IDLE && fetch) vram_addr <= {fx[8:4], row};
         if (state == CAPTURE) hold <= vram_data;
         if (pixel_x == 12'd0 && pixel_y == 12'd0) scroll_lat <= scroll_y;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) sh[i] <= 8'd0;
         for (int i = 0; i < 16; i++) pal[i] <= 8'd0;
         rgb    <= 8'd0;
         out_hs <= 1'b1;
         out_vs <= 1'b1;
         out_de <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) sh[i] <= load ? hold[8*i +: 8] : px[0] ? {sh[i][6:0], 1'b0} : sh[i];
         if (pal_we) pal[pal_addr] <= pal_data;
         rgb    <= !in_de ? 8'd0 : in_win ? pal[idx] : pal[border_idx];
         out_hs <= in_hs;
         out_vs <= in_vs;
         out_de <= in_de;
      end
   end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: randomized bench against a pixel-level reference model of the fetch/palette pipeline
module tb_vga_pixel_fetch;
   localparam int H_START  = 64;
   localparam int ROW_SKIP = 8;
   localparam int LAT      = 3;
   localparam int H_TOT    = 680;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] pixel_x, pixel_y, future_x;
   logic        in_hs, in_vs, in_de;
   logic [7:0]  scroll_y;
   logic [3:0]  border_idx;
   logic        pal_we;
   logic [3:0]  pal_addr;
   logic [7:0]  pal_data;
   logic        vram_rd;
   logic [12:0] vram_addr;
   logic [31:0] vram_data;
   logic [7:0]  rgb;
   logic        out_hs, out_vs, out_de;

   logic [31:0] mem [8192];
   logic        pv [LAT];
   logic [12:0] pa [LAT];
   logic [31:0] junk;

   logic [7:0]  m_pal [16];
   logic [7:0]  m_scroll;
   logic [7:0]  exp_rgb;
   logic        exp_rd, exp_hs, exp_vs, exp_de;
   logic [12:0] exp_addr;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   vga_pixel_fetch #(.H_START(H_START), .ROW_SKIP(ROW_SKIP), .VRAM_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .future_x(future_x),
      .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .scroll_y(scroll_y), .border_idx(border_idx),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .vram_rd(vram_rd),
      .vram_addr(vram_addr), .vram_data(vram_data), .rgb(rgb), .out_hs(out_hs),
      .out_vs(out_vs), .out_de(out_de)
   );

   // VRAM model: data valid exactly LAT cycles after the request, random junk otherwise
   always @(posedge clk) begin
      pv[0] <= vram_rd;
      pa[0] <= vram_addr;
      for (int i = 1; i < LAT; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
      junk <= $urandom;
   end
   assign vram_data = pv[LAT-1] === 1'b1 ? mem[pa[LAT-1]] : junk;

   task automatic cycle(input int h, input logic [11:0] y, input bit act);
      int f, px, p, b;
      logic [7:0]  r;
      logic [31:0] w;
      logic [3:0]  ix;
      pixel_x  = act && h < 640 ? 12'(h) : 12'hfff;
      pixel_y  = act && h < 640 ? y : 12'hfff;
      future_x = act && h + 6 < 640 ? 12'(h + 6) : 12'hfff;
      in_de    = act && h < 640;
      in_hs    = !(h >= 650 && h < 666);
      in_vs    = act || h >= 200;
      f  = int'(future_x) - H_START;
      px = int'(pixel_x) - H_START;
      r  = m_scroll - 8'(ROW_SKIP) - y[8:1];
      if (!reset_n) begin
         exp_rgb = 8'd0; exp_rd = 1'b0; exp_addr = 13'd0;
         exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0;
         m_scroll = 8'd0;
         for (int i = 0; i < 16; i++) m_pal[i] = 8'd0;
      end else begin
         exp_hs = in_hs; exp_vs = in_vs; exp_de = in_de;
         exp_rd = f >= 0 && f < 512 && f % 16 == 0;
         if (exp_rd) exp_addr = {5'(f / 16), r};
         if (!in_de) exp_rgb = 8'd0;
         else if (px >= 0 && px < 512 && pixel_y != 12'hfff) begin
            p = px / 2;
            b = 7 - p % 8;
            w = mem[{5'(p / 8), r}];
            ix = {w[24+b], w[16+b], w[8+b], w[b]};
            exp_rgb = m_pal[ix];
         end else exp_rgb = m_pal[border_idx];
         if (pal_we) m_pal[pal_addr] = pal_data;
         if (pixel_x == 12'd0 && pixel_y == 12'd0) m_scroll = scroll_y;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_pal(input logic [3:0] a, input logic [7:0] d);
      pal_we = 1'b1; pal_addr = a; pal_data = d;
      cycle(H_TOT - 1, 12'hfff, 1'b0);
      pal_we = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pal_we = 1'b1; pal_addr = 4'($urandom); pal_data = 8'($urandom);
         cycle(58 + 16 * i, 12'd0, 1'b1);
         total += 5;
         if (rgb !== 8'h00) begin bad++; $display("FAIL reset_rgb got %h want 00", rgb); end
         if ({out_hs, out_vs} !== 2'b11) begin bad++; $display("FAIL reset_sync got %b want 11", {out_hs, out_vs}); end
         if (out_de !== 1'b0) begin bad++; $display("FAIL reset_de got %b want 0", out_de); end
         if (vram_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got %b want 0", vram_rd); end
         if (vram_addr !== 13'd0) begin bad++; $display("FAIL reset_addr got %h want 0", vram_addr); end
      end
      pal_we = 1'b0;
      reset_n = 1'b1;
      cycle(H_TOT - 1, 12'hfff, 1'b0);
   endtask

   task automatic test_single_line();
      logic [7:0] want;
      int e0 = 0;
      for (int i = 0; i < 8192; i++) mem[i] = 32'h00FF00FF;
      set_pal(4'd5, 8'hE0);
      set_pal(4'd3, 8'h07);
      border_idx = 4'd3;
      for (int h = 0; h < H_TOT; h++) begin
         cycle(h, 12'd0, 1'b1);
         want = h >= 64 && h < 576 ? 8'hE0 : h < 640 ? 8'h07 : 8'h00;
         if (rgb == 8'hE0) e0++;
         total += 3;
         if (rgb !== want) begin bad++; $display("FAIL line_rgb h=%0d got %h want %h", h, rgb, want); end
         if (out_de !== (h < 640)) begin bad++; $display("FAIL line_de h=%0d got %b", h, out_de); end
         if (vram_rd !== exp_rd) begin bad++; $display("FAIL line_rd h=%0d got %b want %b", h, vram_rd, exp_rd); end
      end
      total++;
      if (e0 != 512) begin bad++; $display("FAIL line_e0_count got %0d want 512", e0); end
   endtask

   task automatic test_fetch_cadence();
      logic [4:0] cols [$];
      int first_h = -1;
      for (int i = 0; i < 8192; i++) mem[i] = $urandom;
      for (int i = 0; i < 16; i++) set_pal(4'(i), 8'($urandom));
      for (int h = 0; h < H_TOT; h++) begin
         cycle(h, 12'd2, 1'b1);
         if (vram_rd === 1'b1) begin
            if (first_h < 0) first_h = h;
            cols.push_back(vram_addr[12:8]);
         end
         total++;
         if (rgb !== exp_rgb) begin bad++; $display("FAIL cad_rgb h=%0d got %h want %h", h, rgb, exp_rgb); end
      end
      total += 2;
      if (cols.size() != 32) begin bad++; $display("FAIL cad_count got %0d want 32", cols.size()); end
      if (first_h != H_START - 6) begin bad++; $display("FAIL cad_first got %0d want %0d", first_h, H_START - 6); end
      foreach (cols[i]) begin
         total++;
         if (cols[i] !== 5'(i)) begin bad++; $display("FAIL cad_col i=%0d got %0d want %0d", i, cols[i], i); end
      end
   endtask

   task automatic test_row_mapping();
      logic [7:0]  want [5] = '{8'hF7, 8'hF7, 8'hF6, 8'hF6, 8'h08};
      logic [11:0] ys [5] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
      logic [7:0]  rw;
      bit          got;
      scroll_y = 8'hFF;
      for (int l = 0; l < 5; l++) begin
         if (l == 3) scroll_y = 8'h10;
         if (l == 4) for (int h = 0; h < H_TOT; h++) cycle(h, 12'hfff, 1'b0);
         got = 1'b0; rw = 8'h00;
         for (int h = 0; h < H_TOT; h++) begin
            cycle(h, ys[l], 1'b1);
            if (vram_rd === 1'b1 && !got) begin got = 1'b1; rw = vram_addr[7:0]; end
            total++;
            if (vram_rd !== exp_rd || (exp_rd && vram_addr !== exp_addr)) begin
               bad++; $display("FAIL row_vram l=%0d h=%0d got %b/%h want %b/%h", l, h, vram_rd, vram_addr, exp_rd, exp_addr);
            end
         end
         total++;
         if (rw !== want[l]) begin bad++; $display("FAIL row_map l=%0d got %h want %h", l, rw, want[l]); end
      end
   endtask

   task automatic test_pattern();
      logic [7:0] seq [8] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
      logic [7:0] want;
      for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
      mem[{5'd0, 8'hF8}] = 32'h000000A5;
      for (int i = 0; i < 16; i++) set_pal(4'(i), 8'(i));
      border_idx = 4'd15;
      scroll_y = 8'h00;
      for (int h = 0; h < H_TOT; h++) begin
         cycle(h, 12'd0, 1'b1);
         want = h >= 64 && h < 80 ? seq[(h - 64) / 2] : h >= 64 && h < 576 ? 8'h00 : h < 640 ? 8'h0F : 8'h00;
         total++;
         if (rgb !== want) begin bad++; $display("FAIL pat_rgb h=%0d got %h want %h", h, rgb, want); end
      end
   endtask

   task automatic test_palette_hazard();
      border_idx = 4'd3;
      set_pal(4'd3, 8'h42);
      for (int h = 0; h < H_TOT; h++) begin
         pal_we = h == 10; pal_addr = 4'd3; pal_data = 8'h1C;
         cycle(h, 12'd4, 1'b1);
         if (h == 10) begin
            total++;
            if (rgb !== 8'h42) begin bad++; $display("FAIL haz_old got %h want 42", rgb); end
         end
         if (h == 11) begin
            total++;
            if (rgb !== 8'h1C) begin bad++; $display("FAIL haz_new got %h want 1c", rgb); end
         end
         total++;
         if (rgb !== exp_rgb) begin bad++; $display("FAIL haz_rgb h=%0d got %h want %h", h, rgb, exp_rgb); end
      end
      pal_we = 1'b0;
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 8192; i++) mem[i] = $urandom;
      for (int h = 0; h < H_TOT; h++) begin
         reset_n = !(h == 139 || h == 140);
         cycle(h, 12'd6, 1'b1);
         if (!reset_n) begin
            total += 2;
            if (vram_rd !== 1'b0) begin bad++; $display("FAIL mrst_rd h=%0d got %b want 0", h, vram_rd); end
            if (rgb !== 8'h00) begin bad++; $display("FAIL mrst_rgb h=%0d got %h want 00", h, rgb); end
         end
      end
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) set_pal(4'(i), 8'($urandom));
      for (int h = 0; h < H_TOT; h++) begin
         cycle(h, 12'd8, 1'b1);
         total += 2;
         if (rgb !== exp_rgb) begin bad++; $display("FAIL mrst_line_rgb h=%0d got %h want %h", h, rgb, exp_rgb); end
         if (vram_rd !== exp_rd || (exp_rd && vram_addr !== exp_addr)) begin
            bad++; $display("FAIL mrst_line_vram h=%0d got %b/%h want %b/%h", h, vram_rd, vram_addr, exp_rd, exp_addr);
         end
      end
   endtask

   task automatic test_random();
      logic [11:0] y;
      for (int i = 0; i < 8192; i++) mem[i] = $urandom;
      for (int l = 0; l < 5; l++) begin
         y = l == 0 || l == 3 ? 12'd0 : 12'($urandom_range(1, 479));
         scroll_y = 8'($urandom);
         for (int h = 0; h < H_TOT; h++) begin
            pal_we = $urandom_range(0, 7) == 0;
            pal_addr = 4'($urandom); pal_data = 8'($urandom); border_idx = 4'($urandom);
            cycle(h, y, 1'b1);
            total += 3;
            if (rgb !== exp_rgb) begin bad++; $display("FAIL rand_rgb l=%0d h=%0d got %h want %h", l, h, rgb, exp_rgb); end
            if (vram_rd !== exp_rd || (exp_rd && vram_addr !== exp_addr)) begin
               bad++; $display("FAIL rand_vram l=%0d h=%0d got %b/%h want %b/%h", l, h, vram_rd, vram_addr, exp_rd, exp_addr);
            end
            if ({out_hs, out_vs, out_de} !== {exp_hs, exp_vs, exp_de}) begin
               bad++; $display("FAIL rand_sync l=%0d h=%0d got %b want %b", l, h, {out_hs, out_vs, out_de}, {exp_hs, exp_vs, exp_de});
            end
         end
      end
      pal_we = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      pixel_x = 12'hfff; pixel_y = 12'hfff; future_x = 12'hfff;
      in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
      scroll_y = 8'd0; border_idx = 4'd0;
      pal_we = 1'b0; pal_addr = 4'd0; pal_data = 8'd0;
      m_scroll = 8'd0;
      exp_addr = 13'd0;
      for (int i = 0; i < 16; i++) m_pal[i] = 8'd0;
      for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
      test_reset();
      test_single_line();
      test_fetch_cadence();
      test_row_mapping();
      test_pattern();
      test_palette_hazard();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
